cmd_dispatch_ctrl: RTL and testbench

CMD_DISPATCH_CTRL -- requirements
Module: cmd_dispatch_ctrl

---
 rtl/cmd_dispatch_pkg.sv | 28 ++
 rtl/cmd_dispatch_ctrl_pwm_bank.sv | 81 ++++++++
 rtl/cmd_dispatch_ctrl.sv | 171 +++++++++++++++++
 tb/tb_cmd_dispatch_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/cmd_dispatch_pkg.sv
// cmd_dispatch_pkg: shared definitions for cmd_dispatch_ctrl.
//   - opcode constants (upper 4 bits of cmdata)
//   - FSM state encoding
//   - id_pattern(): the identification word returned by OP_ID
package cmd_dispatch_pkg;

  localparam logic [3:0] OP_NOP       = 4'd0;
  localparam logic [3:0] OP_READ_BASE = 4'd1;   // 1..8  : read sensor (op-1)
  localparam logic [3:0] OP_PWM_BASE  = 4'd9;   // 9..12 : write duty (op-9)
  localparam logic [3:0] OP_DIFF      = 4'd13;
  localparam logic [3:0] OP_STOP      = 4'd14;
  localparam logic [3:0] OP_ID        = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Repeating "10" pattern; the caller keeps the low w bits.
  function automatic logic [63:0] id_pattern(input int unsigned w);
    logic [63:0] p;
    p = {32{2'b10}};
    if (w < 64) p = p & ((64'd1 << w) - 64'd1);
    return p;
  endfunction

endpackage

// File: rtl/cmd_dispatch_ctrl_pwm_bank.sv
// pwm_bank: N_PWM duty registers with write/clear decode and optional
// watchdog.
// Optional feature macro: WATCHDOG_EN (counter that clears all duties after
// WDOG_CYCLES cycles without a PWM_WR/STOP commit).
// Ports:
//   clk_sm2, rst_n   clock / async active-low reset
//   wr_en_i          commit a duty write this cycle
//   wr_idx_i         duty channel to write
//   wr_data_i        new duty value
//   clr_i            commit STOP: clear all duties this cycle
//   pwm_o            flattened duties, channel k at [k*DATA_W +: DATA_W]
//   wdog_trip_o      one-cycle watchdog expiry strobe
module pwm_bank #(
  parameter int DATA_W      = 8,
  parameter int N_PWM       = 4,
  parameter int WDOG_CYCLES = 1000000
) (
  input  logic                    clk_sm2,
  input  logic                    rst_n,
  input  logic                    wr_en_i,
  input  logic [1:0]              wr_idx_i,
  input  logic [DATA_W-1:0]       wr_data_i,
  input  logic                    clr_i,
  output logic [N_PWM*DATA_W-1:0] pwm_o,
  output logic                    wdog_trip_o
);

  logic [N_PWM*DATA_W-1:0] duty_q;
  logic                    expire;

`ifdef WATCHDOG_EN
  localparam int CNT_W = (WDOG_CYCLES > 2) ? $clog2(WDOG_CYCLES) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic             trip_q;
  logic             commit;

  // A commit on the expiry edge reloads the counter and suppresses the trip.
  assign commit = wr_en_i | clr_i;
  assign expire = !commit && (cnt_q == CNT_W'(WDOG_CYCLES - 1));

  always_ff @(posedge clk_sm2 or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      trip_q <= 1'b0;
    end else if (commit) begin
      cnt_q  <= '0;
      trip_q <= 1'b0;
    end else if (expire) begin
      cnt_q  <= '0;
      trip_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_q + 1'b1;
      trip_q <= 1'b0;
    end
  end

  assign wdog_trip_o = trip_q;
`else
  // No watchdog hardware in this build; the parameter stays referenced so
  // both builds share one parameter list.
  localparam bit WDOG_CFG_OK = (WDOG_CYCLES >= 1);
  assign expire      = 1'b0;
  assign wdog_trip_o = 1'b0 & WDOG_CFG_OK;
`endif

  always_ff @(posedge clk_sm2 or negedge rst_n) begin
    if (!rst_n) begin
      duty_q <= '0;
    end else if (clr_i || expire) begin
      duty_q <= '0;
    end else if (wr_en_i) begin
      for (int k = 0; k < N_PWM; k++) begin
        if (wr_idx_i == 2'(k)) duty_q[k*DATA_W +: DATA_W] <= wr_data_i;
      end
    end
  end

  assign pwm_o = duty_q;

endmodule

// File: rtl/cmd_dispatch_ctrl.sv
// cmd_dispatch_ctrl: accepts 4-bit-opcode commands, executes them against
// the sensor inputs and the PWM duty bank, and returns one response word.
// Optional feature macro: WATCHDOG_EN (see pwm_bank).
// Handshake: a command transfers on a posedge where cmd_valid && cmd_ready;
// cmd_ready is high only in IDLE, so cmd_valid outside IDLE is ignored.
// The response (dout/err) registers one edge after the accept edge and
// dout_valid strobes for exactly one cycle alongside it.
// Ports:
//   clk_sm2, rst_n         clock / async active-low reset
//   cmd_valid, cmd_ready   command handshake
//   cmdata                 [DATA_W+3:DATA_W] opcode, [DATA_W-1:0] payload
//   pdata                  flattened sensors, channel k at [k*DATA_W +: DATA_W]
//   dout, dout_valid, err  response word, strobe, illegal-command strobe
//   pwm                    flattened duty registers
//   wdog_trip              watchdog expiry strobe (0 without WATCHDOG_EN)
//   dbg_state              current FSM state
module cmd_dispatch_ctrl
  import cmd_dispatch_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int N_SENS      = 4,
  parameter int N_PWM       = 4,
  parameter int WDOG_CYCLES = 1000000
) (
  input  logic                     clk_sm2,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [4+DATA_W-1:0]      cmdata,
  input  logic [N_SENS*DATA_W-1:0] pdata,
  output logic [DATA_W-1:0]        dout,
  output logic                     dout_valid,
  output logic                     err,
  output logic [N_PWM*DATA_W-1:0]  pwm,
  output logic                     wdog_trip,
  output logic [1:0]               dbg_state
);

  localparam logic [63:0]       ID_FULL = id_pattern(DATA_W);
  localparam logic [DATA_W-1:0] ID_PAT  = ID_FULL[DATA_W-1:0];

  state_e               state_q, state_d;
  logic [4+DATA_W-1:0]  cmd_q;
  logic [DATA_W-1:0]    dout_q, dout_d;
  logic                 dout_valid_q, err_q;
  logic                 accept, exec;

  logic [3:0]           op;
  logic [DATA_W-1:0]    payload;
  logic [2:0]           rd_idx;
  logic [1:0]           pwm_idx;
  logic [DATA_W-1:0]    rd_word, diff_w;
  logic                 illegal, pwm_wr, pwm_clr;

  // ---------------- FSM ----------------
  always_ff @(posedge clk_sm2 or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    accept    = 1'b0;
    exec      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        accept    = cmd_valid;
        if (cmd_valid) state_d = ST_EXEC;
      end
      ST_EXEC: begin
        exec    = 1'b1;
        state_d = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign dbg_state = state_q;

  // ---------------- decode ----------------
  assign op      = cmd_q[4+DATA_W-1:DATA_W];
  assign payload = cmd_q[DATA_W-1:0];
  // Low opcode bits minus one give the channel for both READ (1..8) and
  // PWM_WR (9..12) ranges without a 4-bit subtract.
  assign rd_idx  = op[2:0] - 3'd1;
  assign pwm_idx = op[1:0] - 2'd1;

  if (N_SENS >= 4) begin : g_diff
    logic [DATA_W:0] sum_a, sum_b;
    assign sum_a  = {1'b0, pdata[0*DATA_W +: DATA_W]} + {1'b0, pdata[2*DATA_W +: DATA_W]};
    assign sum_b  = {1'b0, pdata[1*DATA_W +: DATA_W]} + {1'b0, pdata[3*DATA_W +: DATA_W]};
    assign diff_w = sum_a[DATA_W:1] - sum_b[DATA_W:1];
  end else begin : g_no_diff
    assign diff_w = '0;
  end

  always_comb begin
    rd_word = '0;
    for (int k = 0; k < N_SENS; k++) begin
      if (rd_idx == 3'(k)) rd_word = pdata[k*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    dout_d  = '0;
    illegal = 1'b0;
    pwm_wr  = 1'b0;
    pwm_clr = 1'b0;
    case (op)
      OP_NOP:  dout_d = '0;
      OP_DIFF: begin
        if (N_SENS < 4) illegal = 1'b1;
        else            dout_d  = diff_w;
      end
      OP_STOP: pwm_clr = 1'b1;
      OP_ID:   dout_d  = ID_PAT;
      default: begin
        if (op < OP_PWM_BASE) begin
          if (int'(rd_idx) < N_SENS) dout_d  = rd_word;
          else                       illegal = 1'b1;
        end else begin
          if (int'(pwm_idx) < N_PWM) begin
            pwm_wr = 1'b1;
            dout_d = payload;
          end else begin
            illegal = 1'b1;
          end
        end
      end
    endcase
    if (illegal) dout_d = '0;
  end

  // ---------------- response registers ----------------
  always_ff @(posedge clk_sm2 or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      if (accept) cmd_q  <= cmdata;
      if (exec)   dout_q <= dout_d;
      dout_valid_q <= exec;
      err_q        <= exec & illegal;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign err        = err_q;

  pwm_bank #(
    .DATA_W      (DATA_W),
    .N_PWM       (N_PWM),
    .WDOG_CYCLES (WDOG_CYCLES)
  ) u_pwm_bank (
    .clk_sm2     (clk_sm2),
    .rst_n       (rst_n),
    .wr_en_i     (exec & pwm_wr),
    .wr_idx_i    (pwm_idx),
    .wr_data_i   (payload),
    .clr_i       (exec & pwm_clr),
    .pwm_o       (pwm),
    .wdog_trip_o (wdog_trip)
  );

endmodule

// File: tb/tb_cmd_dispatch_ctrl.sv
// Directed bench for cmd_dispatch_ctrl: driver tasks push hand-computed
// responses into exp_q; a negedge monitor pops and compares every response.
module tb_cmd_dispatch_ctrl;

  localparam int DATA_W = 8;
  localparam int N_SENS = 4;
  localparam int N_PWM  = 4;
  localparam int WDOG   = 16;

  logic                     clk_sm2 = 1'b0;
  logic                     rst_n;
  logic                     cmd_valid;
  logic                     cmd_ready;
  logic [4+DATA_W-1:0]      cmdata;
  logic [N_SENS*DATA_W-1:0] pdata;
  logic [DATA_W-1:0]        dout;
  logic                     dout_valid;
  logic                     err;
  logic [N_PWM*DATA_W-1:0]  pwm;
  logic                     wdog_trip;
  logic [1:0]               dbg_state;

  cmd_dispatch_ctrl #(
    .DATA_W(DATA_W), .N_SENS(N_SENS), .N_PWM(N_PWM), .WDOG_CYCLES(WDOG)
  ) dut (
    .clk_sm2(clk_sm2), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmdata(cmdata), .pdata(pdata), .dout(dout), .dout_valid(dout_valid),
    .err(err), .pwm(pwm), .wdog_trip(wdog_trip), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_sm2 = ~clk_sm2;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int resp_cnt = 0;
  int trip_cnt = 0;
  int n_issued = 0;
  logic prev_dv = 1'b0;

  logic [DATA_W:0] exp_q[$];   // {err, dout}
  int              acc_q[$];   // posedge count of each accept edge

  always @(posedge clk_sm2) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk_sm2) begin
    logic [DATA_W:0] e;
    int a;
    #1;
    if (rst_n && cmd_valid && cmd_ready) acc_q.push_back(cyc + 1);
    if (wdog_trip) trip_cnt++;
    if (dout_valid) begin
      resp_cnt++;
      check("dout_valid_one_cycle", 32'(prev_dv), 32'd0);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_response: got dout=%0h err=%0b expected none", dout, err);
      end else begin
        e = exp_q.pop_front();
        check("dout", 32'(dout), 32'(e[DATA_W-1:0]));
        check("err", 32'(err), 32'(e[DATA_W]));
      end
      if (acc_q.size() > 0) begin
        a = acc_q.pop_front();
        check("latency_edges", 32'(cyc - a), 32'd1);
      end
    end else if (err) begin
      check("err_without_valid", 32'(err), 32'd0);
    end
    prev_dv = dout_valid;
  end

  // ---------------- driver ----------------
  task automatic send_cmd(input logic [3:0] op, input logic [DATA_W-1:0] pl,
                          input logic [DATA_W-1:0] exp_d, input logic exp_e);
    int n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk_sm2);
      n++;
    end
    if (!cmd_ready) begin
      check("cmd_ready_timeout", 32'(cmd_ready), 32'd1);
    end else begin
      exp_q.push_back({exp_e, exp_d});
      n_issued++;
      cmdata    = {op, pl};
      cmd_valid = 1'b1;
      @(negedge clk_sm2);
      cmd_valid = 1'b0;
      repeat (2) @(negedge clk_sm2);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmdata    = '0;
    pdata     = {8'h44, 8'h5C, 8'h22, 8'h11};

    repeat (2) @(negedge clk_sm2);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_dout_valid", 32'(dout_valid), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_pwm", pwm, 32'd0);
    check("rst_wdog_trip", 32'(wdog_trip), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);

    // Release and accept on the very first posedge.
    rst_n = 1'b1;
    send_cmd(4'hF, 8'h00, 8'hAA, 1'b0);
    @(negedge clk_sm2);
    check("dout_hold_id", 32'(dout), 32'hAA);

    // Sensor reads and a PWM write to channel 2.
    send_cmd(4'h3, 8'h00, 8'h5C, 1'b0);
    send_cmd(4'h1, 8'h00, 8'h11, 1'b0);
    send_cmd(4'h4, 8'h00, 8'h44, 1'b0);
    send_cmd(4'hB, 8'h5C, 8'h5C, 1'b0);
    check("pwm_after_ch2_write", pwm, 32'h005C_0000);
    send_cmd(4'h3, 8'hFF, 8'h5C, 1'b0);

    // DIFF: (200+100)/2 - (10+30)/2 = 130; then 0 - 255 wraps to 1.
    pdata = {8'd30, 8'd100, 8'd10, 8'd200};
    send_cmd(4'hD, 8'h00, 8'd130, 1'b0);
    pdata = {8'd255, 8'd0, 8'd255, 8'd0};
    send_cmd(4'hD, 8'h00, 8'h01, 1'b0);

    // PWM ch3, then illegal reads leave the duties untouched.
    send_cmd(4'hC, 8'h7E, 8'h7E, 1'b0);
    check("pwm_after_ch3_write", pwm, 32'h7E5C_0000);
    send_cmd(4'h6, 8'h00, 8'h00, 1'b1);
    send_cmd(4'h5, 8'hAB, 8'h00, 1'b1);
    send_cmd(4'h8, 8'h00, 8'h00, 1'b1);
    check("pwm_after_illegal", pwm, 32'h7E5C_0000);
    send_cmd(4'h0, 8'h99, 8'h00, 1'b0);
    send_cmd(4'hE, 8'h12, 8'h00, 1'b0);
    check("pwm_after_stop", pwm, 32'h0000_0000);

    // cmd_valid held high: ready pattern 1,0,0 and one response per 3 cycles.
    repeat (3) begin
      exp_q.push_back({1'b0, 8'hAA});
      n_issued++;
    end
    cmdata    = {4'hF, 8'h00};
    cmd_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      check("ready_pattern", 32'(cmd_ready), (i % 3 == 0) ? 32'd1 : 32'd0);
      @(negedge clk_sm2);
    end
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk_sm2);

    // Reset asserted while a PWM write is in EXEC: command is discarded.
    send_cmd(4'hA, 8'h33, 8'h33, 1'b0);
    check("pwm_after_ch1_write", pwm, 32'h0000_3300);
    n = resp_cnt;
    cmdata    = {4'h9, 8'h44};
    cmd_valid = 1'b1;
    @(negedge clk_sm2);
    check("state_exec_before_reset", 32'(dbg_state), 32'd1);
    cmd_valid = 1'b0;
    rst_n     = 1'b0;
    @(negedge clk_sm2);
    check("midreset_pwm", pwm, 32'd0);
    check("midreset_dout_valid", 32'(dout_valid), 32'd0);
    check("midreset_cmd_ready", 32'(cmd_ready), 32'd1);
    rst_n = 1'b1;
    acc_q.delete();
    repeat (4) @(negedge clk_sm2);
    check("no_resp_after_reset", 32'(resp_cnt), 32'(n));
    check("pwm_idle_after_reset", pwm, 32'd0);

    // Watchdog behaviour after writing ch0 = 0x80.
    send_cmd(4'h9, 8'h80, 8'h80, 1'b0);
    check("pwm_ch0_written", 32'(pwm[7:0]), 32'h80);
`ifdef WATCHDOG_EN
    n = 0;
    while (!wdog_trip && n < 40) begin
      @(negedge clk_sm2);
      n++;
    end
    // Commit edge C; trip registers on edge C+16, send_cmd returned at C+1.5.
    check("wdog_trip_delay", 32'(n), 32'd15);
    check("pwm_ch0_after_trip", 32'(pwm[7:0]), 32'h00);
    @(negedge clk_sm2);
    check("wdog_trip_pulse", 32'(wdog_trip), 32'd0);
`else
    repeat (40) @(negedge clk_sm2);
    check("pwm_ch0_no_watchdog", 32'(pwm[7:0]), 32'h80);
    check("no_wdog_trip", 32'(trip_cnt), 32'd0);
`endif

    repeat (3) @(negedge clk_sm2);
    check("exp_queue_drained", 32'(exp_q.size()), 32'd0);
    check("response_count", 32'(resp_cnt), 32'(n_issued));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
